// File: rtl/sensor_cond.sv
// ---------------------------------------------------------------------------
// sensor_cond
//   Input conditioning in front of the traffic-light controller. Each channel
//   takes a raw, asynchronous host/board bit and produces:
//     - a debounced level,
//     - a one-cycle pulse on each debounced 0->1 transition,
//     - a sticky request that holds until the controller acknowledges it,
//     - an 8-bit saturating press count for host readback.
//   All channels are independent copies of the same per-channel pipeline.
//
// Ports
//   clk         system clock (okClk)
//   rst_n       asynchronous active-low reset, clears every flop
//   raw_in      [N_CH]    unsynchronised raw input bits
//   req_ack     [N_CH]    per-channel request clear, sampled on clk
//   cnt_clr     1         clears all press counters
//   level       [N_CH]    debounced level
//   rise_pulse  [N_CH]    one-cycle pulse on each debounced rising edge
//   req         [N_CH]    sticky request, set on rise, cleared by req_ack
//   press_cnt   [8*N_CH]  saturating rise counts, channel i at [8i+7:8i]
// ---------------------------------------------------------------------------
module sensor_cond #(
    parameter int N_CH       = 3,
    parameter int DEB_CYCLES = 1000000,
    localparam int CNT_W     = $clog2(DEB_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   raw_in,
    input  logic [N_CH-1:0]   req_ack,
    input  logic              cnt_clr,
    output logic [N_CH-1:0]   level,
    output logic [N_CH-1:0]   rise_pulse,
    output logic [N_CH-1:0]   req,
    output logic [8*N_CH-1:0] press_cnt
);

    // Terminal count of the debounce counter: the level flips on the edge
    // where the counter already reads DEB_CYCLES-1, which gives exactly
    // DEB_CYCLES consecutive disagreeing samples.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            // Registered state
            logic             s1_reg;
            logic             s2_reg;
            logic [CNT_W-1:0] deb_cnt_reg;
            logic             level_reg;
            logic             rise_reg;
            logic             req_reg;
            logic [7:0]       press_reg;

            // Next-state values
            logic [CNT_W-1:0] deb_cnt_next;
            logic             level_next;
            logic             rise_next;
            logic             req_next;
            logic [7:0]       press_next;

            logic             differs;
            logic             at_last;
            logic             rise_now;

            assign differs  = (s2_reg != level_reg);
            assign at_last  = (deb_cnt_reg == DEB_LAST);
            // A rise happens on the edge where a disagreeing high sample
            // completes its debounce window.
            assign rise_now = differs && at_last && s2_reg;

            always_comb begin
                deb_cnt_next = deb_cnt_reg;
                level_next   = level_reg;
                rise_next    = rise_now;
                req_next     = req_reg;
                press_next   = press_reg;

                // Debounce: any agreement restarts the window, so glitches
                // shorter than the window never reach the level.
                if (!differs) begin
                    deb_cnt_next = '0;
                end else if (at_last) begin
                    deb_cnt_next = '0;
                    level_next   = s2_reg;
                end else begin
                    deb_cnt_next = deb_cnt_reg + 1'b1;
                end

                // A new rise wins over an acknowledge on the same edge so the
                // event is never dropped.
                if (rise_now) begin
                    req_next = 1'b1;
                end else if (req_ack[gi]) begin
                    req_next = 1'b0;
                end

                // Clear wins over the stored count, but a coincident rise is
                // still counted as the first press after the clear.
                if (cnt_clr) begin
                    press_next = rise_now ? 8'd1 : 8'd0;
                end else if (rise_now && (press_reg != 8'hFF)) begin
                    press_next = press_reg + 8'd1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_reg      <= 1'b0;
                    s2_reg      <= 1'b0;
                    deb_cnt_reg <= '0;
                    level_reg   <= 1'b0;
                    rise_reg    <= 1'b0;
                    req_reg     <= 1'b0;
                    press_reg   <= 8'd0;
                end else begin
                    s1_reg      <= raw_in[gi];
                    s2_reg      <= s1_reg;
                    deb_cnt_reg <= deb_cnt_next;
                    level_reg   <= level_next;
                    rise_reg    <= rise_next;
                    req_reg     <= req_next;
                    press_reg   <= press_next;
                end
            end

            assign level[gi]              = level_reg;
            assign rise_pulse[gi]         = rise_reg;
            assign req[gi]                = req_reg;
            assign press_cnt[8*gi +: 8]   = press_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sensor_cond.sv
// ---------------------------------------------------------------------------
// tb_sensor_cond
//   Directed bench for sensor_cond with N_CH=3, DEB_CYCLES=4. Inputs change
//   on the falling edge; outputs are sampled 1 time unit after each rising
//   edge. "Edge k" below counts rising edges after the input change.
// ---------------------------------------------------------------------------
module tb_sensor_cond;

    localparam int N_CH = 3;
    localparam int DEB  = 4;

    logic              clk;
    logic              rst_n;
    logic [N_CH-1:0]   raw_in;
    logic [N_CH-1:0]   req_ack;
    logic              cnt_clr;
    logic [N_CH-1:0]   level;
    logic [N_CH-1:0]   rise_pulse;
    logic [N_CH-1:0]   req;
    logic [8*N_CH-1:0] press_cnt;

    int checks = 0;
    int errors = 0;

    sensor_cond #(.N_CH(N_CH), .DEB_CYCLES(DEB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_in     (raw_in),
        .req_ack    (req_ack),
        .cnt_clr    (cnt_clr),
        .level      (level),
        .rise_pulse (rise_pulse),
        .req        (req),
        .press_cnt  (press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        raw_in  = '0;
        req_ack = '0;
        cnt_clr = 1'b0;
        repeat (3) tick();
        if ({level, rise_pulse, req, press_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {level, rise_pulse, req, press_cnt});
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();
        if ({level, rise_pulse, req, press_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_release_idle: got %h expected 0", {level, rise_pulse, req, press_cnt});
        end
        checks++;
        $display("test_reset done");
    endtask

    task automatic test_clean_press();
        @(negedge clk);
        raw_in[0] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (level[0] !== (e >= 6)) begin
                errors++;
                $display("FAIL press_level e%0d: got %b expected %b", e, level[0], e >= 6);
            end
            checks++;
            if (rise_pulse[0] !== (e == 6)) begin
                errors++;
                $display("FAIL press_pulse e%0d: got %b expected %b", e, rise_pulse[0], e == 6);
            end
            checks++;
            if (req[0] !== (e >= 6)) begin
                errors++;
                $display("FAIL press_req e%0d: got %b expected %b", e, req[0], e >= 6);
            end
            checks++;
            if (press_cnt[7:0] !== ((e >= 6) ? 8'd1 : 8'd0)) begin
                errors++;
                $display("FAIL press_cnt0 e%0d: got %0d expected %0d", e, press_cnt[7:0], (e >= 6) ? 1 : 0);
            end
            checks++;
            if ({level[2:1], rise_pulse[2:1], req[2:1], press_cnt[23:8]} !== '0) begin
                errors++;
                $display("FAIL press_other_ch e%0d: got %h expected 0", e,
                         {level[2:1], rise_pulse[2:1], req[2:1], press_cnt[23:8]});
            end
            checks++;
        end
        $display("test_clean_press done");
    endtask

    task automatic test_glitch();
        // 3-cycle glitch on channel 1 must be rejected
        @(negedge clk);
        raw_in[1] = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        raw_in[1] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if ({level[1], rise_pulse[1], req[1], press_cnt[15:8]} !== '0) begin
                errors++;
                $display("FAIL glitch_reject e%0d: got %h expected 0", e,
                         {level[1], rise_pulse[1], req[1], press_cnt[15:8]});
            end
            checks++;
        end
        // 6 stable cycles is long enough
        @(negedge clk);
        raw_in[1] = 1'b1;
        repeat (5) tick();
        if (level[1] !== 1'b0) begin
            errors++;
            $display("FAIL stable_level_early: got %b expected 0", level[1]);
        end
        checks++;
        tick();
        if (level[1] !== 1'b1 || rise_pulse[1] !== 1'b1 || press_cnt[15:8] !== 8'd1) begin
            errors++;
            $display("FAIL stable_rise: got level %b pulse %b cnt %0d expected 1 1 1",
                     level[1], rise_pulse[1], press_cnt[15:8]);
        end
        checks++;
        // falling edge of the level must not pulse
        @(negedge clk);
        raw_in[1] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (rise_pulse[1] !== 1'b0) begin
                errors++;
                $display("FAIL fall_no_pulse e%0d: got %b expected 0", e, rise_pulse[1]);
            end
            checks++;
        end
        if (level[1] !== 1'b0 || req[1] !== 1'b1) begin
            errors++;
            $display("FAIL fall_level_req: got level %b req %b expected 0 1", level[1], req[1]);
        end
        checks++;
        $display("test_glitch done");
    endtask

    task automatic test_ack();
        @(negedge clk);
        req_ack[0] = 1'b1;
        tick();
        if (req[0] !== 1'b0) begin
            errors++;
            $display("FAIL ack_clear: got %b expected 0", req[0]);
        end
        checks++;
        @(negedge clk);
        req_ack[0] = 1'b0;
        // bring channel 0 low, then make a rise coincide with an ack
        raw_in[0] = 1'b0;
        repeat (7) tick();
        if (level[0] !== 1'b0 || req[0] !== 1'b0) begin
            errors++;
            $display("FAIL ack_fall: got level %b req %b expected 0 0", level[0], req[0]);
        end
        checks++;
        @(negedge clk);
        raw_in[0] = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        req_ack[0] = 1'b1;
        tick();
        if (req[0] !== 1'b1 || rise_pulse[0] !== 1'b1) begin
            errors++;
            $display("FAIL ack_vs_rise: got req %b pulse %b expected 1 1", req[0], rise_pulse[0]);
        end
        checks++;
        @(negedge clk);
        req_ack[0] = 1'b0;
        tick();
        if (req[0] !== 1'b1 || rise_pulse[0] !== 1'b0 || press_cnt[7:0] !== 8'd2) begin
            errors++;
            $display("FAIL ack_after: got req %b pulse %b cnt %0d expected 1 0 2",
                     req[0], rise_pulse[0], press_cnt[7:0]);
        end
        checks++;
        $display("test_ack done");
    endtask

    task automatic press_ch2();
        @(negedge clk);
        raw_in[2] = 1'b1;
        repeat (7) tick();
        @(negedge clk);
        raw_in[2] = 1'b0;
        repeat (7) tick();
    endtask

    task automatic test_saturation();
        for (int p = 1; p <= 260; p++) begin
            press_ch2();
            if (p == 1 || p == 254 || p == 255 || p == 256 || p == 260) begin
                if (press_cnt[23:16] !== ((p > 255) ? 8'd255 : 8'(p))) begin
                    errors++;
                    $display("FAIL sat_cnt p%0d: got %0d expected %0d", p, press_cnt[23:16],
                             (p > 255) ? 255 : p);
                end
                checks++;
            end
        end
        @(negedge clk);
        cnt_clr = 1'b1;
        tick();
        @(negedge clk);
        cnt_clr = 1'b0;
        if (press_cnt !== '0) begin
            errors++;
            $display("FAIL clr_all: got %h expected 0", press_cnt);
        end
        checks++;
        // clear coincident with a rise on channel 0
        raw_in[0] = 1'b0;
        repeat (7) tick();
        @(negedge clk);
        raw_in[0] = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        cnt_clr = 1'b1;
        tick();
        @(negedge clk);
        cnt_clr = 1'b0;
        if (press_cnt !== 24'h00_00_01) begin
            errors++;
            $display("FAIL clr_with_rise: got %h expected 000001", press_cnt);
        end
        checks++;
        $display("test_saturation done");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        raw_in[1] = 1'b1;
        repeat (4) tick();   // channel 1 debounce counter now 2, req[0]=1
        if (req[0] !== 1'b1 || level[1] !== 1'b0) begin
            errors++;
            $display("FAIL arst_setup: got req0 %b level1 %b expected 1 0", req[0], level[1]);
        end
        checks++;
        #2;
        rst_n = 1'b0;
        #1;
        if ({level, rise_pulse, req, press_cnt} !== '0) begin
            errors++;
            $display("FAIL arst_immediate: got %h expected 0", {level, rise_pulse, req, press_cnt});
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (level !== ((e >= 6) ? 3'b011 : 3'b000)) begin
                errors++;
                $display("FAIL arst_level e%0d: got %b expected %b", e, level,
                         (e >= 6) ? 3'b011 : 3'b000);
            end
            checks++;
            if (rise_pulse !== ((e == 6) ? 3'b011 : 3'b000)) begin
                errors++;
                $display("FAIL arst_pulse e%0d: got %b expected %b", e, rise_pulse,
                         (e == 6) ? 3'b011 : 3'b000);
            end
            checks++;
        end
        if (press_cnt !== 24'h00_01_01) begin
            errors++;
            $display("FAIL arst_cnt: got %h expected 000101", press_cnt);
        end
        checks++;
        $display("test_async_reset done");
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        raw_in = '0;
        repeat (8) tick();
        @(negedge clk);
        cnt_clr = 1'b1;
        req_ack = '1;
        tick();
        @(negedge clk);
        cnt_clr = 1'b0;
        req_ack = '0;
        if ({level, req, press_cnt} !== '0) begin
            errors++;
            $display("FAIL sim_idle: got %h expected 0", {level, req, press_cnt});
        end
        checks++;
        raw_in = 3'b111;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (level !== ((e >= 6) ? 3'b111 : 3'b000)) begin
                errors++;
                $display("FAIL sim_level e%0d: got %b expected %b", e, level,
                         (e >= 6) ? 3'b111 : 3'b000);
            end
            checks++;
            if (rise_pulse !== ((e == 6) ? 3'b111 : 3'b000)) begin
                errors++;
                $display("FAIL sim_pulse e%0d: got %b expected %b", e, rise_pulse,
                         (e == 6) ? 3'b111 : 3'b000);
            end
            checks++;
        end
        if (press_cnt !== 24'h01_01_01 || req !== 3'b111) begin
            errors++;
            $display("FAIL sim_cnt_req: got cnt %h req %b expected 010101 111", press_cnt, req);
        end
        checks++;
        $display("test_simultaneous done");
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_ack();
        test_saturation();
        test_async_reset();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
